fetch_unit: RTL

//  Instruction-fetch front end of the rv32i core: owns the architectural PC register and

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 106 ++++++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i front end: fetch FSM states and the {pc, instr}
// entry that travels from the fetch buffer to decode.
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Pointer-based FIFO of fetched {pc, instr} entries with a registered head
// that holds its last value while the FIFO is empty.
module fetch_buffer
    import rv32i_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    output logic [31:0]      head_pc,
    output logic [31:0]      head_instr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     push_entry;
    fetch_entry_t     head_q;
    fetch_entry_t     head_n;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             do_push;
    logic             do_pop;

    assign push_entry = '{pc: push_pc, instr: push_instr};

    // Flush dominates: a push or pop in the flush cycle has no effect.
    assign do_push = push && !flush && (cnt != FULL_CNT);
    assign do_pop  = pop  && !flush && (cnt != '0);

    always_comb begin
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        cnt_n    = cnt;
        if (flush) begin
            wr_ptr_n = rd_ptr;
            cnt_n    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_n = cnt + CNT_W'(1);
                2'b01:   cnt_n = cnt - CNT_W'(1);
                default: cnt_n = cnt;
            endcase
        end
    end

    // Next head comes from the array, or bypasses the word being written when
    // that word becomes the head in the same cycle.
    always_comb begin
        head_n = head_q;
        if (cnt_n != '0) begin
            if (do_push && (rd_ptr_n == wr_ptr)) begin
                head_n = push_entry;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr_n;
            cnt    <= cnt_n;
            head_q <= head_n;
        end
    end

    assign head_pc    = head_q.pc;
    assign head_instr = head_q.instr;
    assign count      = cnt;
    assign full       = (cnt == FULL_CNT);
    assign empty      = (cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time,
// buffers responses for decode and drops wrong-path words after a redirect.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends combinationally on the matching ready.
    localparam int unsigned      CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e     state;
    fetch_state_e     state_n;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_n;
    logic [31:0]      req_pc;
    logic [31:0]      req_pc_n;
    logic             discard;
    logic             discard_n;
    logic [31:0]      redir_target;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;

    assign redir_target   = word_align(redir_pc);
    assign imem_req_valid = (state == REQ) && (buf_count < DEPTH_CNT);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = if_valid && if_ready;
    assign if_valid       = !buf_empty;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        discard_n  = discard;
        push       = 1'b0;
        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                if (req_fire) begin
                    state_n    = WAIT;
                    req_pc_n   = fetch_pc;
                    fetch_pc_n = fetch_pc + 32'd4;
                    discard_n  = redir_valid;
                end
            end
            WAIT: begin
                // A response landing with a redirect is wrong-path already;
                // nothing is left in flight, so discard is not armed.
                if (imem_rvalid) begin
                    state_n   = REQ;
                    discard_n = 1'b0;
                    push      = !discard && !redir_valid && !buf_full;
                end else if (redir_valid) begin
                    discard_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (redir_valid) begin
            fetch_pc_n = redir_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            discard  <= discard_n;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redir_valid),
        .push       (push),
        .pop        (pop),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .head_pc    (if_pc),
        .head_instr (if_instr),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

endmodule
